// File: rtl/eth_pkg.sv
// Shared constants and types for the RMII transmit arbitration path.
// N: dibit width, NREQ: source count, IFG_CYCLES/MAX_FRAME_CYCLES/START_TIMEOUT:
// timing limits in clk cycles, tx_arb_state_t: arbiter FSM encoding.
package eth_pkg;

    localparam int unsigned N                = 2;
    localparam int unsigned NREQ             = 2;
    localparam int unsigned IFG_CYCLES       = 96 / N;
    localparam int unsigned MAX_FRAME_CYCLES = 6104;
    localparam int unsigned START_TIMEOUT    = 64;

    localparam int unsigned CNT_W = $clog2(MAX_FRAME_CYCLES + 1);
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XMIT  = 2'd2,
        GAP   = 2'd3
    } tx_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after ptr wins.
// Ports: req (request vector), ptr (search start index),
//        gnt (one-hot winner, 0 when no request), idx (winner index).
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

    logic [31:0] k;

    // Walk offsets from farthest to nearest so the nearest requester lands last.
    always_comb begin
        gnt = '0;
        idx = '0;
        k   = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = (32'(ptr) + 32'(NREQ - 1) - 32'(i)) % 32'(NREQ);
            if (req[PW'(k)]) begin
                gnt            = '0;
                gnt[PW'(k)]    = 1'b1;
                idx            = PW'(k);
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Shares the RMII transmit dibit stream between NREQ frame sources: round-robin
// grant, one-cycle registered data mux, inter-frame gap, start-timeout and
// overrun aborts.
// Ports: clk, rst (async active-low), req/src_axiiv/src_axiid (per-source
//        request, valid, data), gnt (one-hot grant), axiov/axiod (muxed
//        stream), busy (not IDLE), abort (one-cycle pulse).
module eth_tx_arbiter
    import eth_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   src_axiiv,
    input  logic [NREQ*N-1:0] src_axiid,
    output logic [NREQ-1:0]   gnt,
    output logic              axiov,
    output logic [N-1:0]      axiod,
    output logic              busy,
    output logic              abort
);

    localparam int unsigned PW = PTR_W;
    localparam int unsigned CW = CNT_W;

    tx_arb_state_t   state, state_d;
    logic [PW-1:0]   ptr, ptr_d;
    logic [PW-1:0]   win, win_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [NREQ-1:0] gnt_d;
    logic            axiov_d;
    logic [N-1:0]    axiod_d;
    logic            busy_d;
    logic            abort_d;

    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;

    logic            sel_v;
    logic            sel_req;
    logic [N-1:0]    sel_d;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // Select the registered winner's request, valid and data; others are ignored.
    always_comb begin
        sel_v   = 1'b0;
        sel_req = 1'b0;
        sel_d   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                sel_v   = src_axiiv[i];
                sel_req = req[i];
                sel_d   = src_axiid[i*N +: N];
            end
        end
    end

    // Next-state and next-output logic; the counter reloads on every state entry.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        win_d   = win;
        cnt_d   = cnt;
        gnt_d   = gnt;
        axiov_d = 1'b0;
        axiod_d = '0;
        abort_d = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    gnt_d   = arb_gnt;
                    win_d   = arb_idx;
                    ptr_d   = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!sel_req) begin
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sel_v) begin
                    // First dibit is forwarded on entry; cnt then counts the rest.
                    axiov_d = 1'b1;
                    axiod_d = sel_d;
                    cnt_d   = '0;
                    state_d = XMIT;
                end else if (cnt >= CW'(START_TIMEOUT - 1)) begin
                    abort_d = 1'b1;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            XMIT: begin
                // End-of-frame is tested first so it beats a coincident overrun.
                if (!sel_v) begin
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (cnt >= CW'(MAX_FRAME_CYCLES - 1)) begin
                    abort_d = 1'b1;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    axiov_d = 1'b1;
                    axiod_d = sel_d;
                    cnt_d   = cnt + CW'(1);
                end
            end
            GAP: begin
                if (cnt >= CW'(IFG_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            win   <= '0;
            cnt   <= '0;
            gnt   <= '0;
            axiov <= 1'b0;
            axiod <= '0;
            busy  <= 1'b0;
            abort <= 1'b0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
            win   <= win_d;
            cnt   <= cnt_d;
            gnt   <= gnt_d;
            axiov <= axiov_d;
            axiod <= axiod_d;
            busy  <= busy_d;
            abort <= abort_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: grant latency, forwarding, gap length,
// round robin, non-granted isolation, overrun and start-timeout aborts, async reset.
module tb_eth_tx_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] src_axiiv;
    logic [3:0] src_axiid;
    logic [1:0] gnt;
    logic       axiov;
    logic [1:0] axiod;
    logic       busy;
    logic       abort;

    int n_chk;
    int n_pass;
    int n_fail;

    eth_tx_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .src_axiiv (src_axiiv),
        .src_axiid (src_axiid),
        .gnt       (gnt),
        .axiov     (axiov),
        .axiod     (axiod),
        .busy      (busy),
        .abort     (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req       = '0;
        src_axiiv = '0;
        src_axiid = '0;
        #1;
        chk("rst_gnt",   32'(gnt),   32'd0);
        chk("rst_axiov", 32'(axiov), 32'd0);
        chk("rst_axiod", 32'(axiod), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        tick();
        rst = 1'b1;
    endtask

    // Granted source s streams len dibits while the other source toggles valid with data 2'b11.
    task automatic run_frame(input int s, input int len);
        logic [1:0] d;
        logic [1:0] g;
        int         o;
        o = 1 - s;
        g = (s == 0) ? 2'b01 : 2'b10;
        for (int i = 0; i < len; i++) begin
            d                     = 2'((i * 3) + s);
            src_axiiv[s]          = 1'b1;
            src_axiid[s*2 +: 2]   = d;
            src_axiiv[o]          = (i % 2 == 0);
            src_axiid[o*2 +: 2]   = 2'b11;
            tick();
            chk("xmit_axiov", 32'(axiov), 32'd1);
            chk("xmit_axiod", 32'(axiod), 32'(d));
            chk("xmit_gnt",   32'(gnt),   32'(g));
        end
        src_axiiv = '0;
        src_axiid = '0;
        tick();
        chk("eof_axiov", 32'(axiov), 32'd0);
        chk("eof_gnt",   32'(gnt),   32'd0);
        chk("eof_abort", 32'(abort), 32'd0);
    endtask

    // Called on the first gap cycle; returns on the first cycle busy is expected low.
    task automatic gap_chk();
        for (int j = 0; j < 48; j++) begin
            chk("gap_busy",  32'(busy),  32'd1);
            chk("gap_axiov", 32'(axiov), 32'd0);
            chk("gap_axiod", 32'(axiod), 32'd0);
            if (j < 47) tick();
        end
        tick();
        chk("gap_end_busy", 32'(busy), 32'd0);
        chk("gap_end_gnt",  32'(gnt),  32'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;

        // Single source, 60-dibit frame.
        do_reset();
        req = 2'b01;
        tick();
        chk("t1_gnt",  32'(gnt),  32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        run_frame(0, 60);
        req = 2'b00;
        gap_chk();
        tick();
        chk("t1_idle_gnt", 32'(gnt), 32'd0);

        // Both requesting from reset: src0, gap, src1, gap, src0 again.
        do_reset();
        req = 2'b11;
        tick();
        chk("t2_gnt_a", 32'(gnt), 32'd1);
        run_frame(0, 10);
        gap_chk();
        tick();
        chk("t2_gnt_b", 32'(gnt), 32'd2);
        run_frame(1, 12);
        gap_chk();
        tick();
        chk("t2_gnt_c", 32'(gnt), 32'd1);
        // Request withdrawn before valid: back to IDLE with no gap.
        req = 2'b00;
        tick();
        chk("t2_drop_gnt",   32'(gnt),   32'd0);
        chk("t2_drop_busy",  32'(busy),  32'd0);
        chk("t2_drop_abort", 32'(abort), 32'd0);

        // Overrun: valid held for 6200 cycles.
        do_reset();
        req = 2'b01;
        tick();
        chk("t4_gnt", 32'(gnt), 32'd1);
        for (int i = 0; i < 6200; i++) begin
            logic [1:0] d;
            d              = 2'(i + 1);
            src_axiiv[0]   = 1'b1;
            src_axiid[1:0] = d;
            tick();
            if (i < 6104) begin
                chk("t4_axiov", 32'(axiov), 32'd1);
                chk("t4_axiod", 32'(axiod), 32'(d));
                chk("t4_abort", 32'(abort), 32'd0);
            end else if (i == 6104) begin
                chk("t4_abort_pulse", 32'(abort), 32'd1);
                chk("t4_abort_axiov", 32'(axiov), 32'd0);
                chk("t4_abort_gnt",   32'(gnt),   32'd0);
                chk("t4_abort_busy",  32'(busy),  32'd1);
                req = 2'b00;
            end else begin
                chk("t4_post_abort", 32'(abort), 32'd0);
                chk("t4_post_axiov", 32'(axiov), 32'd0);
                chk("t4_post_busy",  32'(busy),  32'(i < 6152));
            end
        end
        src_axiiv = '0;
        src_axiid = '0;

        // Start timeout on src1 while non-granted src0 holds valid.
        do_reset();
        req = 2'b10;
        tick();
        chk("t5_gnt", 32'(gnt), 32'd2);
        src_axiiv = 2'b01;
        src_axiid = 4'b0011;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k < 64) begin
                chk("t5_wait_abort", 32'(abort), 32'd0);
                chk("t5_wait_gnt",   32'(gnt),   32'd2);
                chk("t5_wait_axiov", 32'(axiov), 32'd0);
            end else begin
                chk("t5_abort", 32'(abort), 32'd1);
                chk("t5_gnt0",  32'(gnt),   32'd0);
                chk("t5_busy",  32'(busy),  32'd0);
            end
        end
        req       = 2'b00;
        src_axiiv = '0;
        src_axiid = '0;
        tick();
        chk("t5_pulse_end", 32'(abort), 32'd0);
        chk("t5_idle_busy", 32'(busy),  32'd0);

        // Async reset mid-frame, then fresh arbitration from ptr 0.
        do_reset();
        req = 2'b11;
        tick();
        chk("t6_gnt", 32'(gnt), 32'd1);
        for (int i = 0; i < 5; i++) begin
            src_axiiv      = 2'b01;
            src_axiid[1:0] = 2'(i);
            tick();
        end
        chk("t6_pre_axiov", 32'(axiov), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_gnt",   32'(gnt),   32'd0);
        chk("t6_rst_axiov", 32'(axiov), 32'd0);
        chk("t6_rst_busy",  32'(busy),  32'd0);
        src_axiiv = '0;
        src_axiid = '0;
        tick();
        rst = 1'b1;
        tick();
        chk("t6_regrant", 32'(gnt), 32'd1);
        req = 2'b00;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
